valet_dispatcher: RTL and testbench
===================================

# valet_dispatcher

- Request-side front end for the CAM parking lot.
- Accepts park/retrieve requests from the valet desk over a valid/ready handshake and drives the lot's write/read/tag command port.
- Interprets the lot's match response, tracks occupancy, and returns one status response per request.
- One request in flight at a time; sits between desk logic and the lot instance.

## Interface
- TAG_WIDTH, 16, ticket tag width; must equal the lot's TAG_WIDTH
- DEPTH, 8, lot slot count; must equal the lot's DEPTH
- clk  in  1  clock; single clock domain, rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  dispatcher can accept a request
- req_op  in  1  0 = park, 1 = retrieve
- req_tag  in  TAG_WIDTH  ticket tag
- rsp_valid  out  1  response present
- rsp_ready  in  1  desk accepts response
- rsp_status  out  2  00 OK, 01 FULL, 10 DUP, 11 MISS
- rsp_tag  out  TAG_WIDTH  request tag (park) or lot tag_out (retrieve hit)
- rsp_slot  out  $clog2(DEPTH)  slot index on OK, else 0
- lot_write_en  out  1  to lot write_en
- lot_read_en  out  1  to lot read_en
- lot_tag  out  TAG_WIDTH  to lot tag_in
- lot_match_found  in  1  from lot; registered, valid the cycle after a command or probe
- lot_tag_out  in  TAG_WIDTH  from lot
- lot_match_index  in  $clog2(DEPTH)  from lot
- occupancy  out  $clog2(DEPTH+1)  parked-car count

## Operation
- **FSM states:** IDLE, PROBE, PROBE_CHK, COMMIT, COMMIT_CHK, RESP.
- **Accept:**
  - req_ready = (state == IDLE).
  - On req_valid && req_ready, latch op and tag, then go to PROBE (park) or COMMIT (retrieve).
- **PROBE:** lot_tag = latched tag, both enables 0 (lookup only).
- **PROBE_CHK (park only):** decision priority:
  - lot_match_found = 1 → DUP.
  - else occupancy == DEPTH → FULL.
  - else go to COMMIT.
  - DUP/FULL go straight to RESP.
- **COMMIT:** one-cycle pulse with lot_tag = latched tag:
  - park: lot_write_en = 1.
  - retrieve: lot_read_en = 1.
- **COMMIT_CHK:** sample the lot response:
  - park with match_found = 1 → OK, slot = match_index, occupancy + 1.
  - park with no match → MISS (lot failed to store), occupancy unchanged.
  - retrieve hit → OK, rsp_tag = lot_tag_out, slot = match_index, occupancy − 1.
  - retrieve miss → MISS, occupancy unchanged.
- **RESP:**
  - rsp_valid = 1; rsp_* held stable until rsp_ready.
  - On handshake, go to IDLE.
- **Enables:** lot_write_en and lot_read_en are never both high; both are 0 outside COMMIT.
- **Occupancy:** saturates at 0 and DEPTH and never wraps.
- **Outputs on rejection:** FULL and DUP responses report rsp_slot = 0 and rsp_tag = request tag.

## Timing
- **Reset values:** state IDLE, occupancy 0, all outputs 0, including req_ready; req_ready rises the first cycle after rst deasserts.
- **Latency,** with accept at cycle 0 and rsp_valid first seen at the cycle listed:
  - park OK/MISS: cycle 5.
  - park DUP/FULL: cycle 3.
  - retrieve: cycle 3.
- **Back-to-back:** the next request can be accepted the cycle after the response handshake; minimum spacing is 4 cycles for retrieve, 6 for park.
- **rsp_ready held low:** the FSM stalls in RESP; req_ready stays 0.
- **Inputs after accept:** req_* changes are ignored once accepted.
- **Reset mid-operation:** the in-flight request is dropped with no response, and occupancy clears. The lot shares rst, so both ends clear together.
- **Concurrent update and FULL check:** an occupancy update in COMMIT_CHK is visible to the next request's FULL check.

## Configuration
- **VALET_DUP_CHECK_EN defined:** PROBE/PROBE_CHK are used; DUP status is possible; park latency is 5 cycles.
- **VALET_DUP_CHECK_EN undefined:**
  - Park goes IDLE → COMMIT, with the FULL check done at accept.
  - DUP is never reported; park latency is 3 cycles.
  - PROBE states are not compiled.

## Structure
- **Package valet_pkg holds:**
  - op enum (OP_PARK, OP_RETRIEVE).
  - status enum (ST_OK, ST_FULL, ST_DUP, ST_MISS).
  - FSM state enum.
- **Sub-modules:** none. The FSM, latch registers and occupancy counter fit in one module; the bench instantiates it alongside the lot.

## Test plan
All scenarios use the defaults (TAG_WIDTH 16, DEPTH 8).
- **Park 0x00A5 after reset:** status OK, slot 0, occupancy 1, rsp_valid at cycle 5.
- **Park 0x00A5 again:** status DUP, occupancy stays 1, rsp_valid at cycle 3, lot_write_en never pulses.
- **Park 8 distinct tags, then 0x1234:** ninth response is FULL, occupancy 8.
- **Retrieve 0x00A5 after parking it, then retrieve 0x00A5 again:**
  - first: OK, rsp_tag 0x00A5, occupancy decrements.
  - second: MISS.
- **Hold rsp_ready low 10 cycles:** rsp_* stable, req_ready 0 throughout; accept resumes the cycle after the handshake.
- **Assert rst in COMMIT_CHK:** no response, occupancy 0, req_ready 1 the cycle after rst falls.

Source files
------------

// File: rtl/valet_pkg.sv
// Shared types for the valet dispatcher: request ops, response status codes and FSM states.
package valet_pkg;

  typedef enum logic {
    OP_PARK     = 1'b0,
    OP_RETRIEVE = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    ST_OK   = 2'b00,
    ST_FULL = 2'b01,
    ST_DUP  = 2'b10,
    ST_MISS = 2'b11
  } status_e;

  typedef enum logic [2:0] {
    IDLE,
    PROBE,
    PROBE_CHK,
    COMMIT,
    COMMIT_CHK,
    RESP
  } state_e;

endpackage

// File: rtl/valet_dispatcher.sv
// Desk-side front end for the CAM parking lot: one request in flight, registered lot commands and responses.
// Define VALET_DUP_CHECK_EN to probe the lot for a duplicate tag before every park.
module valet_dispatcher
  import valet_pkg::*;
#(
  parameter int TAG_WIDTH = 16,
  parameter int DEPTH     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_op,
  input  logic [TAG_WIDTH-1:0]       req_tag,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [1:0]                 rsp_status,
  output logic [TAG_WIDTH-1:0]       rsp_tag,
  output logic [$clog2(DEPTH)-1:0]   rsp_slot,
  output logic                       lot_write_en,
  output logic                       lot_read_en,
  output logic [TAG_WIDTH-1:0]       lot_tag,
  input  logic                       lot_match_found,
  input  logic [TAG_WIDTH-1:0]       lot_tag_out,
  input  logic [$clog2(DEPTH)-1:0]   lot_match_index,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  state_e               state;
  op_e                  op_q;
  logic [TAG_WIDTH-1:0] tag_q;

  // Every output is registered: each transition loads the values the next state presents.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      op_q         <= OP_PARK;
      tag_q        <= '0;
      occupancy    <= '0;
      req_ready    <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_status   <= '0;
      rsp_tag      <= '0;
      rsp_slot     <= '0;
      lot_write_en <= 1'b0;
      lot_read_en  <= 1'b0;
      lot_tag      <= '0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            op_q      <= op_e'(req_op);
            tag_q     <= req_tag;
            lot_tag   <= req_tag;
            if (op_e'(req_op) == OP_RETRIEVE) begin
              lot_read_en <= 1'b1;
              state       <= COMMIT;
`ifdef VALET_DUP_CHECK_EN
            end else begin
              state <= PROBE;
            end
`else
            end else if (occupancy == OCC_FULL) begin
              rsp_valid  <= 1'b1;
              rsp_status <= ST_FULL;
              rsp_tag    <= req_tag;
              rsp_slot   <= '0;
              state      <= RESP;
            end else begin
              lot_write_en <= 1'b1;
              state        <= COMMIT;
            end
`endif
          end
        end

`ifdef VALET_DUP_CHECK_EN
        PROBE: state <= PROBE_CHK;

        // A duplicate outranks FULL so the desk learns the car is already parked.
        PROBE_CHK: begin
          if (lot_match_found || occupancy == OCC_FULL) begin
            rsp_valid  <= 1'b1;
            rsp_status <= lot_match_found ? ST_DUP : ST_FULL;
            rsp_tag    <= tag_q;
            rsp_slot   <= '0;
            state      <= RESP;
          end else begin
            lot_write_en <= 1'b1;
            state        <= COMMIT;
          end
        end
`endif

        COMMIT: begin
          lot_write_en <= 1'b0;
          lot_read_en  <= 1'b0;
          state        <= COMMIT_CHK;
        end

        COMMIT_CHK: begin
          rsp_valid <= 1'b1;
          state     <= RESP;
          if (lot_match_found) begin
            rsp_status <= ST_OK;
            rsp_slot   <= lot_match_index;
            if (op_q == OP_PARK) begin
              rsp_tag <= tag_q;
              if (occupancy != OCC_FULL) occupancy <= occupancy + OCC_W'(1);
            end else begin
              rsp_tag <= lot_tag_out;
              if (occupancy != '0) occupancy <= occupancy - OCC_W'(1);
            end
          end else begin
            rsp_status <= ST_MISS;
            rsp_tag    <= tag_q;
            rsp_slot   <= '0;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_valet_dispatcher.sv
// Directed bench for valet_dispatcher driving a behavioural model of the CAM parking lot.
module tb_valet_dispatcher;
  import valet_pkg::*;

  localparam int TW = 16;
  localparam int DEPTH = 8;
`ifdef VALET_DUP_CHECK_EN
  localparam int PARK_LAT = 5;
  localparam int REJ_LAT  = 3;
  localparam int CHK_CYC  = 4;
`else
  localparam int PARK_LAT = 3;
  localparam int REJ_LAT  = 1;
  localparam int CHK_CYC  = 2;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_op;
  logic [TW-1:0] req_tag;
  logic          rsp_valid, rsp_ready;
  logic [1:0]    rsp_status;
  logic [TW-1:0] rsp_tag;
  logic [2:0]    rsp_slot;
  logic          lot_write_en, lot_read_en;
  logic [TW-1:0] lot_tag;
  logic          lot_match_found;
  logic [TW-1:0] lot_tag_out;
  logic [2:0]    lot_match_index;
  logic [3:0]    occupancy;

  int errors = 0;
  int checks = 0;
  int both_en = 0;
  int ready_wait;

  always #5 clk = ~clk;

  valet_dispatcher #(.TAG_WIDTH(TW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
    .rsp_tag(rsp_tag), .rsp_slot(rsp_slot),
    .lot_write_en(lot_write_en), .lot_read_en(lot_read_en), .lot_tag(lot_tag),
    .lot_match_found(lot_match_found), .lot_tag_out(lot_tag_out),
    .lot_match_index(lot_match_index), .occupancy(occupancy)
  );

  // Lot model: registered lookup/store/free, lowest free slot is used on a store.
  logic          lot_v [DEPTH];
  logic [TW-1:0] lot_t [DEPTH];

  always @(posedge clk) begin
    int hit, free_s;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        lot_v[i] <= 1'b0;
        lot_t[i] <= '0;
      end
      lot_match_found <= 1'b0;
      lot_tag_out     <= '0;
      lot_match_index <= '0;
    end else begin
      hit = -1;
      free_s = -1;
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (lot_v[i] && lot_t[i] == lot_tag) hit = i;
        if (!lot_v[i]) free_s = i;
      end
      lot_match_found <= 1'b0;
      lot_tag_out     <= '0;
      lot_match_index <= '0;
      if (lot_write_en) begin
        if (hit >= 0) begin
          lot_match_found <= 1'b1;
          lot_match_index <= 3'(hit);
          lot_tag_out     <= lot_tag;
        end else if (free_s >= 0) begin
          lot_v[free_s]   <= 1'b1;
          lot_t[free_s]   <= lot_tag;
          lot_match_found <= 1'b1;
          lot_match_index <= 3'(free_s);
          lot_tag_out     <= lot_tag;
        end
      end else if (hit >= 0) begin
        lot_match_found <= 1'b1;
        lot_match_index <= 3'(hit);
        lot_tag_out     <= lot_t[hit];
        if (lot_read_en) lot_v[hit] <= 1'b0;
      end
    end
  end

  always @(negedge clk) if (lot_write_en && lot_read_en) both_en++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic sendRequest(input logic op, input logic [TW-1:0] tag);
    ready_wait = 0;
    while (!req_ready && ready_wait < 50) begin
      @(posedge clk); #1;
      ready_wait++;
    end
    if (ready_wait >= 50) checkOutput("accept_timeout", 32'(ready_wait), 32'(0));
    req_valid = 1'b1;
    req_op    = op;
    req_tag   = tag;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op    = ~op;
    req_tag   = ~tag;
  endtask

  // Issues a request and returns the cycle rsp_valid rose plus the response; handshakes if rsp_ready is high.
  task automatic applyStimulus(input logic op, input logic [TW-1:0] tag, output int lat,
                               output int wr, output logic [1:0] st, output logic [TW-1:0] rtag,
                               output logic [2:0] slot);
    sendRequest(op, tag);
    lat = 1;
    wr  = int'(lot_write_en);
    while (!rsp_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
      wr += int'(lot_write_en);
    end
    if (!rsp_valid) checkOutput("rsp_timeout", 32'(lat), 32'(0));
    st   = rsp_status;
    rtag = rsp_tag;
    slot = rsp_slot;
    if (rsp_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic checkResp(input string pfx, input logic op, input logic [TW-1:0] tag,
                           input logic [1:0] exp_st, input logic [TW-1:0] exp_tag,
                           input logic [2:0] exp_slot, input logic [3:0] exp_occ, input int exp_lat);
    int lat, wr;
    logic [1:0] st;
    logic [TW-1:0] rtag;
    logic [2:0] slot;
    applyStimulus(op, tag, lat, wr, st, rtag, slot);
    checkOutput({pfx, "_status"}, 32'(st), 32'(exp_st));
    checkOutput({pfx, "_tag"}, 32'(rtag), 32'(exp_tag));
    checkOutput({pfx, "_slot"}, 32'(slot), 32'(exp_slot));
    checkOutput({pfx, "_occ"}, 32'(occupancy), 32'(exp_occ));
    checkOutput({pfx, "_lat"}, 32'(lat), 32'(exp_lat));
    if (exp_st != 2'(ST_OK) || op == OP_RETRIEVE) checkOutput({pfx, "_wr_pulses"}, 32'(wr), 32'(0));
  endtask

  initial begin
    int lat, wr, bad;
    logic [1:0] st;
    logic [TW-1:0] rtag;
    logic [2:0] slot;

    rst = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_tag = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_req_ready", 32'(req_ready), 32'(0));
    checkOutput("rst_occ", 32'(occupancy), 32'(0));
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    checkOutput("rst_lot_en", 32'({lot_write_en, lot_read_en}), 32'(0));
    rst = 1'b0;
    #1;
    checkOutput("ready_before_edge", 32'(req_ready), 32'(0));
    @(posedge clk); #1;
    checkOutput("ready_after_rst", 32'(req_ready), 32'(1));

    checkResp("park_a5", OP_PARK, 16'h00A5, 2'(ST_OK), 16'h00A5, 3'd0, 4'd1, PARK_LAT);
`ifdef VALET_DUP_CHECK_EN
    checkResp("park_a5_dup", OP_PARK, 16'h00A5, 2'(ST_DUP), 16'h00A5, 3'd0, 4'd1, 3);
`endif
    checkResp("ret_a5", OP_RETRIEVE, 16'h00A5, 2'(ST_OK), 16'h00A5, 3'd0, 4'd0, 3);
    checkResp("ret_a5_again", OP_RETRIEVE, 16'h00A5, 2'(ST_MISS), 16'h00A5, 3'd0, 4'd0, 3);

    for (int i = 0; i < DEPTH; i++)
      checkResp($sformatf("fill%0d", i), OP_PARK, 16'h0100 + 16'(i), 2'(ST_OK),
                16'h0100 + 16'(i), 3'(i), 4'(i + 1), PARK_LAT);
    checkResp("park_full", OP_PARK, 16'h1234, 2'(ST_FULL), 16'h1234, 3'd0, 4'd8, REJ_LAT);
    checkResp("ret_103", OP_RETRIEVE, 16'h0103, 2'(ST_OK), 16'h0103, 3'd3, 4'd7, 3);
    checkResp("park_1234", OP_PARK, 16'h1234, 2'(ST_OK), 16'h1234, 3'd3, 4'd8, PARK_LAT);

    // Response stall: outputs must hold and no new request may be accepted.
    rsp_ready = 1'b0;
    applyStimulus(OP_RETRIEVE, 16'h0105, lat, wr, st, rtag, slot);
    checkOutput("stall_status", 32'(st), 32'(ST_OK));
    checkOutput("stall_tag", 32'(rtag), 32'h0105);
    checkOutput("stall_slot", 32'(slot), 32'd5);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (!rsp_valid || rsp_status !== st || rsp_tag !== rtag || rsp_slot !== slot || req_ready) bad++;
    end
    checkOutput("stall_stable", 32'(bad), 32'(0));
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("stall_release_valid", 32'(rsp_valid), 32'(0));
    checkOutput("stall_release_ready", 32'(req_ready), 32'(1));
    checkResp("ret_106", OP_RETRIEVE, 16'h0106, 2'(ST_OK), 16'h0106, 3'd6, 4'd6, 3);
    checkOutput("ret_106_ready_wait", 32'(ready_wait), 32'(0));

    // Reset while the lot response is being sampled.
    sendRequest(OP_PARK, 16'h0777);
    repeat (CHK_CYC - 1) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midrst_occ", 32'(occupancy), 32'(0));
    checkOutput("midrst_ready_low", 32'(req_ready), 32'(0));
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (rsp_valid) bad++;
      @(posedge clk); #1;
      if (i == 0) checkOutput("midrst_ready_high", 32'(req_ready), 32'(1));
    end
    checkOutput("midrst_no_rsp", 32'(bad), 32'(0));
    checkResp("park_after_rst", OP_PARK, 16'h00A5, 2'(ST_OK), 16'h00A5, 3'd0, 4'd1, PARK_LAT);

    checkOutput("enables_exclusive", 32'(both_en), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
